serial_add_ctrl: RTL and testbench
==================================

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits (legal range 2..32).
REQ-002 clk  input  1  rising-edge clock; all state changes on this edge only.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request to begin an addition; sampled each rising edge.
REQ-005 a  input  WIDTH  addend A; captured only when start is accepted.
REQ-006 b  input  WIDTH  addend B; captured only when start is accepted.
REQ-007 cin  input  1  carry-in; captured only when start is accepted.
REQ-008 busy  output  1  high while an addition is in progress (state RUN).
REQ-009 done  output  1  single-cycle pulse; sum/cout valid from this cycle.
REQ-010 sum  output  WIDTH  registered result, held until the next completion.
REQ-011 cout  output  1  registered carry-out, held until the next completion.

Function
REQ-012 The block SHALL compute {cout,sum} = a + b + cin bit-serially, LSB first, using exactly one 1-bit full-adder cell per cycle.
REQ-013 The FSM SHALL have three states: IDLE, RUN, DONE.
REQ-014 IDLE: if start=1, capture a, b into shift registers, load carry register with cin, clear bit counter, go to RUN; else stay.
REQ-015 RUN: each cycle apply bit 0 of both shift registers plus carry register to the cell, shift sum bit into the result shift register from the MSB side, shift operands right by one, update carry register, increment counter.
REQ-016 RUN SHALL last exactly WIDTH cycles; on the edge processing bit WIDTH-1, load sum and cout output registers and go to DONE.
REQ-017 DONE: done=1 for exactly one cycle; if start=1 in DONE it SHALL be accepted as in IDLE (back-to-back), else go to IDLE.
REQ-018 Latency: start sampled at edge k -> done high in the cycle after edge k+WIDTH+1 is not allowed; done SHALL be high during the cycle following edge k+WIDTH.
REQ-019 start while in RUN SHALL be ignored; a, b, cin changes while in RUN SHALL have no effect.
REQ-020 sum and cout SHALL change only on the edge entering DONE; stable otherwise.
REQ-021 busy=1 exactly in RUN; done=1 exactly in DONE; both combinational decodes of the state register.
REQ-022 Counter width SHALL be ceil(log2(WIDTH)) bits; no wrap is reachable because RUN exits at WIDTH-1.

Reset
REQ-023 rst=1 at an edge SHALL force state IDLE, sum=0, cout=0, carry register=0, counter=0, shift registers=0; busy=0, done=0 in the following cycle.
REQ-024 rst SHALL take priority over start in every state; an addition interrupted by reset SHALL produce no done pulse and leave sum/cout at 0.

Structure
REQ-025 State encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and default WIDTH SHALL live in shared package serial_add_pkg.
REQ-026 The 1-bit adder SHALL be a separate combinational sub-module fa_bit (inputs a,b,c; outputs s,cary), instantiated once.
REQ-027 Unused state encoding 2'd3 SHALL transition to IDLE.

Verification (WIDTH=8)
REQ-028 a=0x0F, b=0x01, cin=0, start 1 cycle -> busy 8 cycles, done on cycle 9 after start edge, sum=0x10, cout=0.
REQ-029 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
REQ-030 Start run a=0x12,b=0x34; pulse start with a=0xAA,b=0xAA at cycle 3 of RUN -> ignored, result sum=0x46, cout=0, single done.
REQ-031 Assert rst at cycle 4 of RUN -> busy=0, no done pulse, sum=0, cout=0; next start a=0x01,b=0x02 -> sum=0x03.
REQ-032 Hold start high continuously with a=0x80,b=0x80,cin=0 -> done every 9 cycles, each sum=0x00, cout=1, busy low only during DONE cycles.
REQ-033 Random a, b, cin for 1000 operations SHALL match a reference model a+b+cin with zero mismatches.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared state encoding and default width for the bit-serial adder controller.
package serial_add_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_add_ctrl_fa_bit.sv
// Single-bit combinational full adder used as the serial adder's only arithmetic cell.
module fa_bit (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic cary
);

    assign s    = a ^ b ^ c;
    assign cary = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: adds a + b + cin LSB first, one full-adder bit per
// cycle, and presents a registered {cout,sum} with a one-cycle done pulse.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, sum_q, sum_d;
    logic             c_q, c_d, cout_q, cout_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             load;
    logic             fa_s, fa_c;

    fa_bit u_fa (
        .a   (a_q[0]),
        .b   (b_q[0]),
        .c   (c_q),
        .s   (fa_s),
        .cary(fa_c)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        load    = 1'b0;

        case (state_q)
            IDLE: load = start;
            RUN: begin
                a_d   = {1'b0, a_q[WIDTH-1:1]};
                b_d   = {1'b0, b_q[WIDTH-1:1]};
                c_d   = fa_c;
                res_d = {fa_s, res_q[WIDTH-1:1]};
                cnt_d = cnt_q + CW'(1);
                // Final bit: publish the result straight from the cell, not from res_q
                if (cnt_q == LAST) begin
                    sum_d   = {fa_s, res_q[WIDTH-1:1]};
                    cout_d  = fa_c;
                    state_d = DONE;
                end
            end
            DONE: begin
                load    = start;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            a_d     = a;
            b_d     = b;
            c_d     = cin;
            cnt_d   = '0;
            state_d = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and random checks of serial_add_ctrl at WIDTH=8.
module tb_serial_add_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] a = '0, b = '0;
    logic       cin = 1'b0;
    logic       busy, done, cout;
    logic [7:0] sum;

    int total = 0;
    int bad   = 0;

    serial_add_ctrl #(.WIDTH(8)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .a    (a),
        .b    (b),
        .cin  (cin),
        .busy (busy),
        .done (done),
        .sum  (sum),
        .cout (cout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] s;
        logic       co;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Launch one addition and wait for done; returns result, cycles to done and busy count.
    task automatic do_op(input logic [7:0] va, input logic [7:0] vb, input logic vc,
                         output logic [7:0] rs, output logic rc,
                         output int lat, output int nbusy);
        @(negedge clk);
        a = va; b = vb; cin = vc; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a = ~va; b = ~vb; cin = ~vc;
        lat = 1;
        nbusy = 0;
        while (!done && lat < 40) begin
            if (busy) nbusy++;
            @(negedge clk);
            lat++;
        end
        rs = sum;
        rc = cout;
    endtask

    initial begin
        logic [7:0] rs;
        logic       rc;
        int         lat, nb, pulses;
        logic [8:0] ref9;

        vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[4] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
        vecs[5] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
        vecs[6] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
        vecs[7] = '{8'h3C, 8'hC3, 1'b0, 8'hFF, 1'b0};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_state", {busy, done, cout, sum}, 11'h000);

        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].cin, rs, rc, lat, nb);
            chk($sformatf("vec%0d_result", i), {rc, rs}, {vecs[i].co, vecs[i].s});
            chk($sformatf("vec%0d_latency", i), lat, 9);
            chk($sformatf("vec%0d_busy_cycles", i), nb, 8);
        end

        // Start pulse during RUN must be ignored
        @(negedge clk);
        a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        pulses = 0;
        rs = 8'h00; rc = 1'b1;
        for (int n = 1; n <= 24; n++) begin
            @(negedge clk);
            start = (n == 3);
            if (n == 3) begin a = 8'hAA; b = 8'hAA; end
            else begin a = 8'h5C; b = 8'hC5; end
            if (done) begin
                pulses++;
                rs = sum;
                rc = cout;
                chk("ignore_done_cycle", n, 9);
            end
        end
        start = 1'b0;
        chk("ignore_result", {rc, rs}, 9'h046);
        chk("ignore_single_done", pulses, 1);

        // Reset in the middle of RUN aborts silently
        @(negedge clk);
        a = 8'hF0; b = 8'h0F; cin = 1'b1; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_reset_busy", busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("reset_abort_state", {busy, done, cout, sum}, 11'h000);
        pulses = 0;
        for (int n = 0; n < 12; n++) begin
            if (done) pulses++;
            @(negedge clk);
        end
        chk("reset_abort_no_done", pulses, 0);
        chk("reset_abort_sum_held", {cout, sum}, 9'h000);
        do_op(8'h01, 8'h02, 1'b0, rs, rc, lat, nb);
        chk("after_reset_result", {rc, rs}, 9'h003);

        // Back-to-back: start held high
        @(negedge clk);
        a = 8'h80; b = 8'h80; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 36; n++) begin
            @(negedge clk);
            chk($sformatf("b2b_flags_c%0d", n), {busy, done},
                (n % 9 == 0) ? 2'b01 : 2'b10);
            if (n % 9 == 0)
                chk($sformatf("b2b_result_c%0d", n), {cout, sum}, 9'h100);
        end
        start = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // Random operations against plain integer addition
        for (int i = 0; i < 1000; i++) begin
            logic [7:0] ra, rb;
            logic       rcin;
            ra = 8'($urandom);
            rb = 8'($urandom);
            rcin = 1'($urandom);
            ref9 = {1'b0, ra} + {1'b0, rb} + {8'h00, rcin};
            do_op(ra, rb, rcin, rs, rc, lat, nb);
            chk($sformatf("rand%0d", i), {rc, rs, lat[7:0]}, {ref9, 8'd9});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
